// File: rtl/mac_pkg.sv
// Shared widths, fixed-point types and the round/saturate helper for the LSTM datapath.
// The helper is used by the activation blocks, which run at the default widths.
package mac_pkg;

    localparam int DWIDTH = 16;
    localparam int FRAC   = 8;
    localparam int AWIDTH = 40;

    typedef logic signed [DWIDTH-1:0]   data_t;
    typedef logic signed [2*DWIDTH-1:0] prod_t;
    typedef logic signed [AWIDTH-1:0]   acc_t;

    typedef struct packed {
        data_t y;
        logic  clipped;
    } rs_t;

    // Round half toward +inf, shift down by FRAC, then clip to the data range.
    // One guard bit keeps the rounding add from wrapping near the accumulator top.
    function automatic rs_t round_sat(input acc_t a);
        logic signed [AWIDTH:0] r;
        logic signed [AWIDTH:0] ymax;
        logic signed [AWIDTH:0] ymin;
        rs_t o;
        ymax = {{(AWIDTH-DWIDTH+2){1'b0}}, {(DWIDTH-1){1'b1}}};
        ymin = {{(AWIDTH-DWIDTH+2){1'b1}}, {(DWIDTH-1){1'b0}}};
        r = {a[AWIDTH-1], a};
        if (FRAC > 0) begin
            r = r + ((AWIDTH+1)'(1) << (FRAC-1));
        end
        r = r >>> FRAC;
        o.clipped = 1'b0;
        o.y       = r[DWIDTH-1:0];
        if (r > ymax) begin
            o.y       = ymax[DWIDTH-1:0];
            o.clipped = 1'b1;
        end else if (r < ymin) begin
            o.y       = ymin[DWIDTH-1:0];
            o.clipped = 1'b1;
        end
        return o;
    endfunction

endpackage

// File: rtl/mac_sat_round.sv
// Combinational rounding and saturation of the accumulator into the operand format.
// Parameterised so the output stage follows whatever widths the MAC is built with.
module sat_round #(
    parameter int DWIDTH = mac_pkg::DWIDTH,
    parameter int FRAC   = mac_pkg::FRAC,
    parameter int AWIDTH = mac_pkg::AWIDTH
) (
    input  logic signed [AWIDTH-1:0] acc,
    output logic signed [DWIDTH-1:0] y,
    output logic                     clipped
);

    localparam logic signed [AWIDTH:0] YMAX = {{(AWIDTH-DWIDTH+2){1'b0}}, {(DWIDTH-1){1'b1}}};
    localparam logic signed [AWIDTH:0] YMIN = {{(AWIDTH-DWIDTH+2){1'b1}}, {(DWIDTH-1){1'b0}}};

    logic signed [AWIDTH:0] ext;
    logic signed [AWIDTH:0] rnd;
    logic signed [AWIDTH:0] shf;

    assign ext = {acc[AWIDTH-1], acc};

    // With no fractional bits there is nothing to round away.
    generate
        if (FRAC > 0) begin : g_round
            assign rnd = ext + ((AWIDTH+1)'(1) << (FRAC-1));
        end else begin : g_no_round
            assign rnd = ext;
        end
    endgenerate

    assign shf = rnd >>> FRAC;

    always_comb begin
        clipped = 1'b0;
        y       = shf[DWIDTH-1:0];
        if (shf > YMAX) begin
            y       = YMAX[DWIDTH-1:0];
            clipped = 1'b1;
        end else if (shf < YMIN) begin
            y       = YMIN[DWIDTH-1:0];
            clipped = 1'b1;
        end
    end

endmodule

// File: rtl/mac.sv
// Signed fixed-point multiply-accumulate lane: multiply (P), saturating accumulate (A),
// round/clip output (O). One term per cycle, result valid two edges after the last term.
module mac #(
    parameter int DWIDTH = mac_pkg::DWIDTH,
    parameter int FRAC   = mac_pkg::FRAC,
    parameter int AWIDTH = mac_pkg::AWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              first,
    input  logic              last,
    input  logic [DWIDTH-1:0] x,
    input  logic [DWIDTH-1:0] w,
    output logic [DWIDTH-1:0] y,
    output logic              valid,
    output logic              sat
);

    localparam logic [AWIDTH-1:0] AMAX = {1'b0, {(AWIDTH-1){1'b1}}};
    localparam logic [AWIDTH-1:0] AMIN = {1'b1, {(AWIDTH-1){1'b0}}};

    // Stage P
    logic signed [2*DWIDTH-1:0] p_prod;
    logic                       p_vld;
    logic                       p_first;
    logic                       p_last;

    // Stage A
    logic signed [AWIDTH-1:0] acc;
    logic                     ovf;
    logic                     a_vld;
    logic                     a_last;

    logic signed [AWIDTH-1:0] prod_ext;
    logic        [AWIDTH:0]   sum;
    logic                     add_ovf;
    logic        [AWIDTH-1:0] sum_sat;

    // Stage O
    logic signed [DWIDTH-1:0] rnd_y;
    logic                     rnd_clip;

    always_ff @(posedge clk) begin
        if (rst) begin
            p_prod  <= '0;
            p_vld   <= 1'b0;
            p_first <= 1'b0;
            p_last  <= 1'b0;
        end else begin
            p_vld <= en;
            if (en) begin
                p_prod  <= $signed(x) * $signed(w);
                p_first <= first;
                p_last  <= last;
            end
        end
    end

    // One extra sum bit exposes signed overflow; on overflow pin to the rail of the true sign.
    assign prod_ext = AWIDTH'(p_prod);
    assign sum      = {acc[AWIDTH-1], acc} + {prod_ext[AWIDTH-1], prod_ext};
    assign add_ovf  = sum[AWIDTH] ^ sum[AWIDTH-1];
    assign sum_sat  = add_ovf ? (sum[AWIDTH] ? AMIN : AMAX) : sum[AWIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            ovf    <= 1'b0;
            a_vld  <= 1'b0;
            a_last <= 1'b0;
        end else begin
            a_vld  <= p_vld;
            a_last <= p_vld & p_last;
            if (p_vld) begin
                if (p_first) begin
                    acc <= prod_ext;
                    ovf <= 1'b0;
                end else begin
                    acc <= sum_sat;
                    ovf <= ovf | add_ovf;
                end
            end
        end
    end

    sat_round #(
        .DWIDTH(DWIDTH),
        .FRAC  (FRAC),
        .AWIDTH(AWIDTH)
    ) u_sat_round (
        .acc    (acc),
        .y      (rnd_y),
        .clipped(rnd_clip)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            y     <= '0;
            valid <= 1'b0;
            sat   <= 1'b0;
        end else if (a_vld && a_last) begin
            y     <= rnd_y;
            valid <= 1'b1;
            sat   <= ovf | rnd_clip;
        end else begin
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac.sv
// Directed bench for the mac lane: hand-computed Q8.8 dot products checked for value,
// sat flag, pulse count and latency.
module tb_mac;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        first;
    logic        last;
    logic [15:0] x;
    logic [15:0] w;
    logic [15:0] y;
    logic        valid;
    logic        sat;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // {sat, y} of every valid pulse, and the edge count it was seen after
    logic [16:0] obs_q[$];
    int          obs_t[$];
    logic [16:0] exp_q[$];
    int          exp_t[$];

    mac dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .first(first),
        .last (last),
        .x    (x),
        .w    (w),
        .y    (y),
        .valid(valid),
        .sat  (sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            obs_q.push_back({sat, y});
            obs_t.push_back(cyc);
        end
    end

    task automatic term(input logic f, input logic l, input logic [15:0] xv, input logic [15:0] wv);
        @(negedge clk);
        en    = 1'b1;
        first = f;
        last  = l;
        x     = xv;
        w     = wv;
    endtask

    // Idle cycles carry junk on the ignored inputs.
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            en    = 1'b0;
            first = 1'($urandom_range(0, 1));
            last  = 1'($urandom_range(0, 1));
            x     = 16'($urandom_range(0, 65535));
            w     = 16'($urandom_range(0, 65535));
        end
    endtask

    task automatic start_test;
        obs_q.delete();
        obs_t.delete();
        exp_q.delete();
        exp_t.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        en  = 1'b0;
        first = 1'b0;
        last  = 1'b0;
        x = '0;
        w = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (y !== 16'h0000) begin errors++; $display("FAIL reset_y got %h exp 0000", y); end
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
        checks++;
        if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat got %b exp 0", sat); end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_single;
        start_test();
        term(1, 1, 16'h0100, 16'h0200);
        exp_t.push_back(cyc + 3);
        exp_q.push_back({1'b0, 16'h0200});
        idle(6);
        checks++;
        if (obs_q.size() !== 1) begin
            errors++; $display("FAIL single_count got %0d exp 1", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL single_value got %h exp %h", obs_q[0], exp_q[0]); end
            checks++;
            if (obs_t[0] !== exp_t[0]) begin errors++; $display("FAIL single_latency got %0d exp %0d", obs_t[0], exp_t[0]); end
        end
    endtask

    task automatic test_dot3;
        start_test();
        term(1, 0, 16'h0100, 16'h0100);
        term(0, 0, 16'h0200, 16'h0080);
        term(0, 1, 16'hFE80, 16'h0200);
        exp_t.push_back(cyc + 3);
        exp_q.push_back({1'b0, 16'hFF00});
        idle(6);
        checks++;
        if (obs_q.size() !== 1) begin
            errors++; $display("FAIL dot3_count got %0d exp 1", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL dot3_value got %h exp %h", obs_q[0], exp_q[0]); end
            checks++;
            if (obs_t[0] !== exp_t[0]) begin errors++; $display("FAIL dot3_latency got %0d exp %0d", obs_t[0], exp_t[0]); end
        end
    endtask

    task automatic test_round;
        start_test();
        term(1, 1, 16'h0001, 16'h0080);
        term(1, 1, 16'hFFFF, 16'h0080);
        exp_q.push_back({1'b0, 16'h0001});
        exp_q.push_back({1'b0, 16'h0000});
        idle(6);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL round_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL round_value[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_saturation;
        start_test();
        term(1, 0, 16'h7FFF, 16'h7FFF);
        term(0, 1, 16'h7FFF, 16'h7FFF);
        term(1, 1, 16'h0100, 16'h0100);
        term(1, 1, 16'h8000, 16'h7FFF);
        exp_q.push_back({1'b1, 16'h7FFF});
        exp_q.push_back({1'b0, 16'h0100});
        exp_q.push_back({1'b1, 16'h8000});
        idle(6);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL sat_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL sat_value[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
            end
        end
    endtask

    // Accumulator pinned at its positive rail must stay there, so the later
    // negative terms land at -1 -> y=0 with sat held only by the sticky flag.
    task automatic test_acc_saturation;
        start_test();
        term(1, 0, 16'h8000, 16'h8000);
        repeat (519) term(0, 0, 16'h8000, 16'h8000);
        repeat (512) term(0, 0, 16'h8000, 16'h7FFF);
        term(0, 1, 16'h8000, 16'h0200);
        term(1, 1, 16'h0100, 16'h0100);
        exp_q.push_back({1'b1, 16'h0000});
        exp_q.push_back({1'b0, 16'h0100});
        idle(6);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL accsat_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL accsat_value[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_bubbles;
        start_test();
        term(1, 0, 16'h0100, 16'h0100);
        idle(2);
        term(0, 0, 16'h0200, 16'h0080);
        idle(1);
        term(0, 1, 16'hFE80, 16'h0200);
        exp_q.push_back({1'b0, 16'hFF00});
        idle(6);
        checks++;
        if (obs_q.size() !== 1) begin
            errors++; $display("FAIL bubble_count got %0d exp 1", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL bubble_value got %h exp %h", obs_q[0], exp_q[0]); end
        end
    endtask

    // Two dot products with no gap, then a continuation term without first.
    task automatic test_back_to_back;
        int t0;
        start_test();
        term(1, 0, 16'h0100, 16'h0300);
        term(0, 1, 16'h0080, 16'h0100);
        t0 = cyc + 3;
        term(1, 1, 16'h0200, 16'hFF00);
        term(0, 1, 16'h0100, 16'h0100);
        exp_q.push_back({1'b0, 16'h0380}); exp_t.push_back(t0);
        exp_q.push_back({1'b0, 16'hFE00}); exp_t.push_back(t0 + 1);
        exp_q.push_back({1'b0, 16'hFF00}); exp_t.push_back(t0 + 2);
        idle(6);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL b2b_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_value[%0d] got %h exp %h", i, obs_q[i], exp_q[i]); end
                checks++;
                if (obs_t[i] !== exp_t[i]) begin errors++; $display("FAIL b2b_time[%0d] got %0d exp %0d", i, obs_t[i], exp_t[i]); end
            end
        end
    endtask

    task automatic test_reset_mid;
        start_test();
        term(1, 0, 16'h0300, 16'h0100);
        term(0, 1, 16'h0100, 16'h0100);
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(6);
        checks++;
        if (obs_q.size() !== 0) begin errors++; $display("FAIL rstmid_count got %0d exp 0", obs_q.size()); end
        checks++;
        if (y !== 16'h0000) begin errors++; $display("FAIL rstmid_y got %h exp 0000", y); end
        checks++;
        if (sat !== 1'b0) begin errors++; $display("FAIL rstmid_sat got %b exp 0", sat); end
        start_test();
        term(1, 1, 16'h0100, 16'h0300);
        exp_q.push_back({1'b0, 16'h0300});
        idle(6);
        checks++;
        if (obs_q.size() !== 1) begin
            errors++; $display("FAIL rstmid_fresh_count got %0d exp 1", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL rstmid_fresh_value got %h exp %h", obs_q[0], exp_q[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_dot3();
        test_round();
        test_saturation();
        test_acc_saturation();
        test_bubbles();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac.md
Name: mac

Overview:
- Signed fixed-point multiply-accumulate unit for the LSTM datapath.
- Computes dot products for gate pre-activations, sum(x_i*w_i), one term per cycle.
- Streams operand pairs, accumulates at full precision, then emits a rounded, saturated result in the input format.
- Instantiated once per gate lane; consumed by the activation stage.

Parameters:
- DWIDTH, 16: operand/result width, two's complement.
- FRAC, 8: fractional bits of operands and result (Q8.8 default).
- AWIDTH, 40: accumulator width; must be >= 2*DWIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  operand pair valid this cycle.
- first  in  1  with en: term starts a new dot product (load, not add).
- last  in  1  with en: term ends the dot product.
- x  in  DWIDTH  signed operand (activation).
- w  in  DWIDTH  signed operand (weight).
- y  out  DWIDTH  signed result, Q(DWIDTH-FRAC).FRAC.
- valid  out  1  one-cycle pulse, y holds new dot product.
- sat  out  1  y was clipped (sticky per dot product, presented with valid).

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). On rst: all pipeline registers, the accumulator, y, valid and sat go to 0. This includes any in-flight terms.
- Pipeline stage P (edge k): if en, the register receives prod = x*w (signed, 2*DWIDTH bits), and first/last/en are registered alongside.
- Stage A (edge k+1), if the stage-P valid bit is set:
  - acc <= first ? sext(prod) : acc + sext(prod).
  - The accumulator add saturates to the AWIDTH signed range; it never wraps.
  - Any saturation sets the sticky ovf flag. A first term clears ovf before applying its own overflow.
- Stage O (edge k+2), if the stage-A term carried last:
  - y <= sat_DWIDTH(round(acc >>> FRAC)).
  - valid <= 1 and sat <= ovf | clipped.
  - Otherwise valid <= 0; y and sat hold.
- Rounding: add 2^(FRAC-1) before the arithmetic shift (round half toward +inf). If FRAC=0, no rounding.
- Output clip range: [-2^(DWIDTH-1), 2^(DWIDTH-1)-1].
- Latency: the last term sampled at edge k gives valid high after edge k+2. Throughput is 1 term/cycle; back-to-back dot products need no bubble.
- first and last on the same term: a single-term product.
- en=0 cycles: bubbles. The accumulator holds and the pipeline valid bits clear.
- first, last, x and w are ignored when en=0.
- A term without first, following a completed dot product, keeps adding to the previous acc. This is legal (continuation).
- valid never asserts for a dot product lacking last.

Decomposition:
- Shared package mac_pkg holds:
  - default widths DWIDTH/FRAC/AWIDTH;
  - typedefs for data_t (signed DWIDTH), prod_t (signed 2*DWIDTH), acc_t (signed AWIDTH);
  - a rounding-and-saturation function reused by the activation blocks.
- One sub-module is natural: sat_round. It is combinational, takes acc_t and produces data_t plus a clipped flag, and instantiates in stage O.
- Multiply and accumulate stay inline.

Test Plan:
- Reset then a single term with first=last=1, x=0x0100 (1.0), w=0x0200 (2.0) -> valid pulses 3 edges later, y=0x0200, sat=0.
- 3-term dot product, back-to-back:
  - inputs (1.0,1.0), (2.0,0.5), (-1.5,2.0), i.e. 0x0100/0x0100, 0x0200/0x0080, 0xFE80/0x0200;
  - required: y=0xFF00 (-1.0), single valid pulse, sat=0.
- Rounding: x=0x0001, w=0x0080 -> y=0x0001. Also x=0xFFFF, w=0x0080 -> y=0x0000 (half rounds up).
- Saturation:
  - two terms 0x7FFF*0x7FFF -> y=0x7FFF, sat=1;
  - next dot product, 0x0100*0x0100 with first -> y=0x0100, sat=0;
  - 0x8000*0x7FFF -> y=0x8000, sat=1.
- Bubbles and back-to-back:
  - terms separated by en=0 gaps give the same result as gapless;
  - two dot products with the second's first immediately after the first's last -> two valid pulses 1 cycle apart, with independent results.
- Reset mid-operation: assert rst while 2 terms are in flight -> no valid ever appears for them, y=0, and a fresh dot product afterward is correct.
